// File: rtl/lcd_write_cycle_ctrl.sv
// lcd_write_cycle_ctrl
//   Bus-timing stage for an HD44780-compatible character LCD. Takes one
//   8-bit byte plus RS per transaction, drives setup / enable pulse / hold
//   on the parallel bus, waits the command execution time, then pulses oDone.
//   Write-only: LCD_RW is held low and the busy flag is never read.
//
// Ports
//   iCLK      system clock (50 MHz)
//   iRST_N    asynchronous active-low reset
//   iDATA     byte to write
//   iRS       register select (0 = command, 1 = data)
//   iStart    request level; a rising edge seen in IDLE starts a transaction
//   oDone     one-cycle completion pulse
//   oBusy     high from acceptance through the oDone cycle
//   LCD_DATA  LCD data bus (changes only at acceptance)
//   LCD_RW    constant 0
//   LCD_EN    LCD enable strobe
//   LCD_RS    LCD register select (changes only at acceptance)
module lcd_write_cycle_ctrl #(
  parameter int unsigned T_AS        = 4,
  parameter int unsigned T_PW        = 16,
  parameter int unsigned T_H         = 4,
  parameter int unsigned T_EXEC      = 2000,
  parameter int unsigned T_EXEC_LONG = 82000,
  parameter int unsigned CNT_W       = 17
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] iDATA,
  input  logic       iRS,
  input  logic       iStart,
  output logic       oDone,
  output logic       oBusy,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] AS_LAST   = CNT_W'(T_AS - 1);
  localparam logic [CNT_W-1:0] PW_LAST   = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(T_H - 1);
  localparam logic [CNT_W-1:0] EXEC_LAST = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(T_EXEC_LONG - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             start_q;
  logic             long_q;
  logic             accept;

  assign LCD_RW = 1'b0;

  always_comb begin
    accept  = iStart & ~start_q;
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)                                   state_d = SETUP;
      SETUP:   if (cnt_q == AS_LAST)                         state_d = PULSE;
      PULSE:   if (cnt_q == PW_LAST)                         state_d = HOLD;
      HOLD:    if (cnt_q == H_LAST)                          state_d = EXEC;
      EXEC:    if (cnt_q == (long_q ? LONG_LAST : EXEC_LAST)) state_d = DONE;
      DONE:                                                  state_d = IDLE;
      default:                                               state_d = IDLE;
    endcase
  end

  // Outputs are registered from state_d so LCD_EN/oDone/oBusy change on the
  // same edge as the state they belong to.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      long_q   <= 1'b0;
      oDone    <= 1'b0;
      oBusy    <= 1'b0;
      LCD_EN   <= 1'b0;
      LCD_RS   <= 1'b0;
      LCD_DATA <= '0;
    end else begin
      start_q <= iStart;
      state_q <= state_d;

      // Held at zero while idle so it never free-runs and wraps.
      if (state_d != state_q || state_q == IDLE) cnt_q <= '0;
      else                                       cnt_q <= cnt_q + CNT_W'(1);

      if (state_q == IDLE && state_d == SETUP) begin
        LCD_DATA <= iDATA;
        LCD_RS   <= iRS;
        // Clear-display and return-home need the long execution wait.
        long_q   <= ~iRS & (iDATA == 8'h01 || iDATA == 8'h02 || iDATA == 8'h03);
      end

      LCD_EN <= (state_d == PULSE);
      oDone  <= (state_d == DONE);
      oBusy  <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_lcd_write_cycle_ctrl.sv
module tb_lcd_write_cycle_ctrl;

  localparam int unsigned P_AS   = 2;
  localparam int unsigned P_PW   = 3;
  localparam int unsigned P_H    = 2;
  localparam int unsigned P_EX   = 5;
  localparam int unsigned P_LONG = 20;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic [7:0] iDATA = '0;
  logic       iRS = 1'b0;
  logic       iStart = 1'b0;
  logic       oDone, oBusy, LCD_RW, LCD_EN, LCD_RS;
  logic [7:0] LCD_DATA;

  int compared = 0;
  int mismatched = 0;
  int en_rises = 0;

  lcd_write_cycle_ctrl #(
    .T_AS(P_AS), .T_PW(P_PW), .T_H(P_H), .T_EXEC(P_EX), .T_EXEC_LONG(P_LONG), .CNT_W(17)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iDATA(iDATA), .iRS(iRS), .iStart(iStart),
    .oDone(oDone), .oBusy(oBusy), .LCD_DATA(LCD_DATA), .LCD_RW(LCD_RW),
    .LCD_EN(LCD_EN), .LCD_RS(LCD_RS)
  );

  always #5 iCLK = ~iCLK;

  always @(posedge LCD_EN) en_rises++;

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one transaction from request to the cycle after oDone, then optionally
  // keeps iStart high for hold_after cycles and finally drops it for one cycle.
  task automatic run_txn(input string tag, input logic [7:0] d, input logic r,
                         input int exp_done, input int glitch_at, input int hold_after);
    int en_first, en_cnt, done_at, bus_ok, extra;
    iDATA = d; iRS = r; iStart = 1'b1;
    tick();                                   // edge k
    chk({tag, " data@k"}, 32'(LCD_DATA), 32'(d));
    chk({tag, " rs@k"},   32'(LCD_RS),   32'(r));
    chk({tag, " busy@k"}, 32'(oBusy),    32'd1);
    chk({tag, " en@k"},   32'(LCD_EN),   32'd0);
    iDATA = ~d; iRS = ~r;                     // must not reach the bus
    en_first = -1; en_cnt = 0; done_at = -1; bus_ok = 1;
    for (int n = 1; n <= 200 && done_at < 0; n++) begin
      if (n == glitch_at)     iStart = 1'b0;
      if (n == glitch_at + 1) iStart = 1'b1;
      tick();                                 // edge k+n
      if (LCD_EN === 1'b1) begin
        if (en_first < 0) en_first = n;
        en_cnt++;
      end
      if (LCD_DATA !== d || LCD_RS !== r || LCD_RW !== 1'b0) bus_ok = 0;
      if (oDone === 1'b1) done_at = n;
    end
    chk({tag, " en_rise"},  32'(en_first), 32'd2);
    chk({tag, " en_width"}, 32'(en_cnt),   32'd3);
    chk({tag, " done_at"},  32'(done_at),  32'(exp_done));
    chk({tag, " bus_hold"}, 32'(bus_ok),   32'd1);
    tick();
    chk({tag, " done_pulse"}, 32'(oDone), 32'd0);
    chk({tag, " busy_off"},   32'(oBusy), 32'd0);
    extra = 0;
    for (int n = 0; n < hold_after; n++) begin
      tick();
      if (LCD_EN !== 1'b0 || oBusy !== 1'b0) extra = 1;
    end
    if (hold_after > 0) chk({tag, " held_no_restart"}, 32'(extra), 32'd0);
    iStart = 1'b0;
    tick();
  endtask

  logic [8:0] seq [38];
  string      l1, l2;
  int         rises0, done_at;

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst busy", 32'(oBusy), 32'd0);
    chk("rst done", 32'(oDone), 32'd0);
    chk("rst en",   32'(LCD_EN), 32'd0);
    chk("rst rs",   32'(LCD_RS), 32'd0);
    chk("rst data", 32'(LCD_DATA), 32'd0);
    chk("rst rw",   32'(LCD_RW), 32'd0);
    #3 iRST_N = 1'b1;
    tick();

    // 1. data write; 2./3. long/short decision
    run_txn("wr41",   8'h41, 1'b1, 12, 0, 0);
    run_txn("clr01",  8'h01, 1'b0, 27, 0, 0);
    run_txn("home02", 8'h02, 1'b0, 27, 0, 0);
    run_txn("cmd03",  8'h03, 1'b0, 27, 0, 0);
    run_txn("cmd38",  8'h38, 1'b0, 12, 0, 0);
    run_txn("cmd0C",  8'h0C, 1'b0, 12, 0, 0);
    run_txn("cmd04",  8'h04, 1'b0, 12, 0, 0);
    run_txn("cmd00",  8'h00, 1'b0, 12, 0, 0);
    run_txn("rs1_01", 8'h01, 1'b1, 12, 0, 0);

    // 4. handshake: held iStart, re-raise, mid-EXEC glitch ignored
    rises0 = en_rises;
    run_txn("hold",   8'h5A, 1'b1, 12, 0, 10);
    run_txn("glitch", 8'hA5, 1'b0, 12, 8, 0);
    chk("hs en_pulses", 32'(en_rises - rises0), 32'd2);

    // 5. upstream stream: init, line 1, 0xC0, line 2
    l1 = "Hello, World 123";
    l2 = "LCD write cycle!";
    seq[0] = {1'b0, 8'h38}; seq[1] = {1'b0, 8'h0C}; seq[2] = {1'b0, 8'h01};
    seq[3] = {1'b0, 8'h06}; seq[4] = {1'b0, 8'h80};
    for (int i = 0; i < 16; i++) seq[5 + i] = {1'b1, l1[i]};
    seq[21] = {1'b0, 8'hC0};
    for (int i = 0; i < 16; i++) seq[22 + i] = {1'b1, l2[i]};
    rises0 = en_rises;
    for (int i = 0; i < 38; i++)
      run_txn($sformatf("seq%0d", i), seq[i][7:0], seq[i][8],
              (seq[i] == 9'h001) ? 27 : 12, 0, 0);
    chk("seq en_pulses", 32'(en_rises - rises0), 32'd38);

    // 6. asynchronous reset during PULSE, iStart held high
    iDATA = 8'h55; iRS = 1'b1; iStart = 1'b1;
    tick();                                   // edge k
    tick(); tick(); tick();                   // k+3, inside PULSE
    chk("pre_rst en", 32'(LCD_EN), 32'd1);
    #2 iRST_N = 1'b0;
    #1;
    chk("async en",   32'(LCD_EN), 32'd0);
    chk("async busy", 32'(oBusy), 32'd0);
    chk("async data", 32'(LCD_DATA), 32'd0);
    chk("async rs",   32'(LCD_RS), 32'd0);
    #2 iRST_N = 1'b1;
    tick();                                   // first edge after release
    chk("restart busy", 32'(oBusy), 32'd1);
    chk("restart data", 32'(LCD_DATA), 32'h55);
    done_at = -1;
    for (int n = 1; n <= 200 && done_at < 0; n++) begin
      tick();
      if (oDone === 1'b1) done_at = n;
    end
    chk("restart done_at", 32'(done_at), 32'd12);
    iStart = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
